sphere3hopf_arbiter: RTL and testbench
======================================

Name: sphere3hopf_arbiter

Overview:
- Shares one sphere3hopf_32bit point generator between NUM_REQ independent requesters.
- Arbitrates pop and reseed requests round-robin and sequences the generator's pop/valid handshake.
- Returns each 4-D point (x, y, z, w; Q1.31) to the requester that asked for it, with a per-requester ready/valid response.
- Sits between the requesting blocks and a single generator instance, so there is no replicated generator datapath.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester index; must equal clog2(NUM_REQ).
- TIMEOUT, 64, maximum cycles to wait for gen_valid before aborting a pop.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset; all state clears immediately on assertion.
- req_pop  in  NUM_REQ  per-requester point request; level, held until granted.
- req_reseed  in  NUM_REQ  per-requester reseed request; level, held until acknowledged.
- req_seed  in  NUM_REQ*32  per-requester seed; slice k is bits [32k+31:32k].
- reseed_ack  out  NUM_REQ  one-cycle pulse when requester k's reseed has been issued.
- rsp_valid  out  NUM_REQ  one-hot; point available for requester k.
- rsp_ready  in  NUM_REQ  requester k accepts the point.
- rsp_x, rsp_y, rsp_z, rsp_w  out  32 each  registered point data, shared bus.
- rsp_id  out  ID_W  index of the current rsp_valid owner.
- gen_pop  out  1  pop strobe to the generator.
- gen_reseed  out  1  reseed strobe to the generator.
- gen_seed  out  32  seed to the generator.
- gen_valid  in  1  generator result strobe.
- gen_x, gen_y, gen_z, gen_w  in  32 each  generator result data.
- busy  out  1  FSM is not in IDLE.
- timeout_err  out  1  sticky; set on any timeout, cleared only by reset.

Behaviour:
- Reset values: FSM=IDLE; all outputs 0; rr_ptr=0.
- FSM states: IDLE, RESEED, ISSUE, WAIT, DELIVER.
- IDLE arbitration:
  - Active request vector = req_pop | req_reseed.
  - Scan round-robin starting at rr_ptr, lowest index wins ties after rotation.
  - Latch the winner as cur_id; go to RESEED if req_reseed[cur_id] is high, else ISSUE.
  - With no request pending, stay in IDLE.
- RESEED (1 cycle):
  - gen_reseed=1 and gen_seed=req_seed slice of cur_id.
  - reseed_ack[cur_id]=1 in the same cycle.
  - rr_ptr := cur_id+1 (mod NUM_REQ); next state IDLE.
  - If the same requester has both reseed and pop pending, the reseed is served first. The pop is served at that requester's next turn.
- ISSUE (1 cycle): gen_pop=1 for exactly one cycle; timeout counter := 0; next state WAIT.
- WAIT:
  - gen_pop=0; the counter increments each cycle.
  - On gen_valid: register gen_x..w into rsp_x..w, rsp_id := cur_id, go to DELIVER.
  - If the counter reaches TIMEOUT-1 without gen_valid: set timeout_err, rr_ptr := cur_id+1, go to IDLE. The request is not consumed; the requester keeps req_pop high and is re-arbitrated.
  - gen_valid arriving in any state other than WAIT is ignored.
- DELIVER:
  - rsp_valid[cur_id]=1; data stays stable while waiting.
  - When rsp_ready[cur_id] is high: rsp_valid drops the next cycle, rr_ptr := cur_id+1, next state IDLE.
  - rsp_ready from other requesters is ignored.
  - If req_pop[cur_id] drops while in WAIT or DELIVER, delivery still completes.
- Grant point: a requester's pop counts as granted when the FSM enters ISSUE for its index. The requester must drop req_pop on the rsp_valid&rsp_ready cycle if it wants exactly one point.
- Latency: best case 1 (arbitrate) + 1 (ISSUE) + generator latency + 1 from req_pop to rsp_valid.
- Throughput: at most one outstanding generator operation at any time.
- Reset mid-operation: the FSM returns to IDLE asynchronously and rsp_valid, gen_pop and gen_reseed drop at once. A gen_valid arriving after reset is ignored.
- busy=1 in every state except IDLE.

Test Plan:
- Single requester: after reset, req_pop[0]=1 → gen_pop pulses exactly once. Return gen_valid with x=0x4000_0000, w=0xC000_0000 → rsp_valid=0001, rsp_id=0, rsp_x=0x4000_0000, rsp_w=0xC000_0000. Data holds until rsp_ready[0]=1.
- Round-robin fairness: req_pop=1111 held for 8 points → rsp_id sequence 0,1,2,3,0,1,2,3. No requester is served twice while another is waiting.
- Reseed priority: req_reseed[2]=1 with req_seed slice 2 = 5, and req_pop[2]=1 → gen_reseed pulse with gen_seed=5 and reseed_ack=0100 first. The pop for requester 2 is served on its following turn.
- Backpressure: rsp_ready[1]=0 for 10 cycles → rsp_valid[1] and the data stay stable, no gen_pop is issued, busy=1. On rsp_ready[1]=1 the FSM returns to IDLE one cycle later.
- Timeout: gen_valid never asserted → after 64 WAIT cycles timeout_err=1 and FSM returns to IDLE. The requester is re-arbitrated and a new gen_pop follows; timeout_err stays 1.
- Async reset during WAIT: drop rst_n mid-wait → all outputs 0 immediately. A late gen_valid after release produces no rsp_valid.

Source files
------------

// File: rtl/sphere3hopf_arbiter.sv
// Round-robin front end that shares one sphere3hopf_32bit point generator between
// NUM_REQ requesters, serving reseeds before pops and aborting pops that time out.
module sphere3hopf_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_pop,
  input  logic [NUM_REQ-1:0]      req_reseed,
  input  logic [NUM_REQ*32-1:0]   req_seed,
  output logic [NUM_REQ-1:0]      reseed_ack,
  output logic [NUM_REQ-1:0]      rsp_valid,
  input  logic [NUM_REQ-1:0]      rsp_ready,
  output logic [31:0]             rsp_x,
  output logic [31:0]             rsp_y,
  output logic [31:0]             rsp_z,
  output logic [31:0]             rsp_w,
  output logic [ID_W-1:0]         rsp_id,
  output logic                    gen_pop,
  output logic                    gen_reseed,
  output logic [31:0]             gen_seed,
  input  logic                    gen_valid,
  input  logic [31:0]             gen_x,
  input  logic [31:0]             gen_y,
  input  logic [31:0]             gen_z,
  input  logic [31:0]             gen_w,
  output logic                    busy,
  output logic                    timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, RESEED, ISSUE, WAIT, DELIVER} state_t;

  state_t             state_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    cur_id_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [NUM_REQ-1:0] reseed_ack_q;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic [31:0]        rsp_x_q;
  logic [31:0]        rsp_y_q;
  logic [31:0]        rsp_z_q;
  logic [31:0]        rsp_w_q;
  logic [ID_W-1:0]    rsp_id_q;
  logic               gen_pop_q;
  logic               gen_reseed_q;
  logic [31:0]        gen_seed_q;
  logic               busy_q;
  logic               timeout_err_q;

  logic [NUM_REQ-1:0] active_s;
  logic [ID_W:0]      rot_s;
  logic [ID_W-1:0]    rot_id_s;
  logic [ID_W-1:0]    grant_id_d;
  logic               grant_vld_d;
  logic [31:0]        seed_sel_d;

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    if (id == ID_W'(NUM_REQ - 1)) begin
      return {ID_W{1'b0}};
    end else begin
      return id + ID_W'(1);
    end
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

  // Round-robin winner: scan from the highest rotation offset down so the lowest offset wins.
  always_comb begin
    active_s    = req_pop | req_reseed;
    rot_s       = {(ID_W+1){1'b0}};
    rot_id_s    = {ID_W{1'b0}};
    grant_id_d  = {ID_W{1'b0}};
    grant_vld_d = 1'b0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      rot_s = {1'b0, rr_ptr_q} + (ID_W+1)'(i);
      if (rot_s >= (ID_W+1)'(NUM_REQ)) begin
        rot_s = rot_s - (ID_W+1)'(NUM_REQ);
      end else begin
        rot_s = rot_s;
      end
      rot_id_s = rot_s[ID_W-1:0];
      if (active_s[rot_id_s]) begin
        grant_id_d  = rot_id_s;
        grant_vld_d = 1'b1;
      end else begin
        grant_vld_d = grant_vld_d;
      end
    end
  end

  // Seed slice belonging to the arbitration winner.
  always_comb begin
    seed_sel_d = 32'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (ID_W'(k) == grant_id_d) begin
        seed_sel_d = req_seed[k*32 +: 32];
      end else begin
        seed_sel_d = seed_sel_d;
      end
    end
  end

  // Sequencer; every strobe is set on entry to the state that owns it and cleared on exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= {ID_W{1'b0}};
      cur_id_q      <= {ID_W{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      reseed_ack_q  <= {NUM_REQ{1'b0}};
      rsp_valid_q   <= {NUM_REQ{1'b0}};
      rsp_x_q       <= 32'd0;
      rsp_y_q       <= 32'd0;
      rsp_z_q       <= 32'd0;
      rsp_w_q       <= 32'd0;
      rsp_id_q      <= {ID_W{1'b0}};
      gen_pop_q     <= 1'b0;
      gen_reseed_q  <= 1'b0;
      gen_seed_q    <= 32'd0;
      busy_q        <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            cur_id_q <= grant_id_d;
            busy_q   <= 1'b1;
            if (req_reseed[grant_id_d]) begin
              state_q      <= RESEED;
              gen_reseed_q <= 1'b1;
              gen_seed_q   <= seed_sel_d;
              reseed_ack_q <= onehot(grant_id_d);
            end else begin
              state_q   <= ISSUE;
              gen_pop_q <= 1'b1;
            end
          end
        end
        RESEED: begin
          gen_reseed_q <= 1'b0;
          gen_seed_q   <= 32'd0;
          reseed_ack_q <= {NUM_REQ{1'b0}};
          rr_ptr_q     <= next_id(cur_id_q);
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
        ISSUE: begin
          gen_pop_q <= 1'b0;
          cnt_q     <= {CNT_W{1'b0}};
          state_q   <= WAIT;
        end
        WAIT: begin
          if (gen_valid) begin
            rsp_x_q     <= gen_x;
            rsp_y_q     <= gen_y;
            rsp_z_q     <= gen_z;
            rsp_w_q     <= gen_w;
            rsp_id_q    <= cur_id_q;
            rsp_valid_q <= onehot(cur_id_q);
            state_q     <= DELIVER;
          end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
            timeout_err_q <= 1'b1;
            rr_ptr_q      <= next_id(cur_id_q);
            busy_q        <= 1'b0;
            state_q       <= IDLE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DELIVER: begin
          if (rsp_ready[cur_id_q]) begin
            rsp_valid_q <= {NUM_REQ{1'b0}};
            rr_ptr_q    <= next_id(cur_id_q);
            busy_q      <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: begin
          gen_pop_q    <= 1'b0;
          gen_reseed_q <= 1'b0;
          reseed_ack_q <= {NUM_REQ{1'b0}};
          rsp_valid_q  <= {NUM_REQ{1'b0}};
          busy_q       <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign reseed_ack  = reseed_ack_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_x       = rsp_x_q;
  assign rsp_y       = rsp_y_q;
  assign rsp_z       = rsp_z_q;
  assign rsp_w       = rsp_w_q;
  assign rsp_id      = rsp_id_q;
  assign gen_pop     = gen_pop_q;
  assign gen_reseed  = gen_reseed_q;
  assign gen_seed    = gen_seed_q;
  assign busy        = busy_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_sphere3hopf_arbiter.sv
// Directed bench for sphere3hopf_arbiter: reset, single pop, round-robin, reseed priority,
// backpressure, timeout and asynchronous reset during WAIT.
module tb_sphere3hopf_arbiter;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_pop;
  logic [3:0]   req_reseed;
  logic [127:0] req_seed;
  logic [3:0]   reseed_ack;
  logic [3:0]   rsp_valid;
  logic [3:0]   rsp_ready;
  logic [31:0]  rsp_x, rsp_y, rsp_z, rsp_w;
  logic [1:0]   rsp_id;
  logic         gen_pop;
  logic         gen_reseed;
  logic [31:0]  gen_seed;
  logic         gen_valid;
  logic [31:0]  gen_x, gen_y, gen_z, gen_w;
  logic         busy;
  logic         timeout_err;

  int n_cmp = 0;
  int n_err = 0;
  int pop_cnt = 0;

  sphere3hopf_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_pop(req_pop), .req_reseed(req_reseed), .req_seed(req_seed),
    .reseed_ack(reseed_ack), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_x(rsp_x), .rsp_y(rsp_y), .rsp_z(rsp_z), .rsp_w(rsp_w), .rsp_id(rsp_id),
    .gen_pop(gen_pop), .gen_reseed(gen_reseed), .gen_seed(gen_seed),
    .gen_valid(gen_valid), .gen_x(gen_x), .gen_y(gen_y), .gen_z(gen_z), .gen_w(gen_w),
    .busy(busy), .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count generator pop pulses, one per cycle in which gen_pop is high.
  always @(negedge clk) if (gen_pop === 1'b1) pop_cnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; req_pop = 4'b0; req_reseed = 4'b0; req_seed = 128'd0; rsp_ready = 4'b0;
    gen_valid = 1'b0; gen_x = 32'd0; gen_y = 32'd0; gen_z = 32'd0; gen_w = 32'd0;
    tick(); tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_pop(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (gen_pop === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // From ISSUE: one WAIT cycle, then the generator answers; returns in DELIVER.
  task automatic gen_return(input logic [31:0] x, input logic [31:0] y,
                            input logic [31:0] z, input logic [31:0] w);
    tick();
    gen_valid = 1'b1; gen_x = x; gen_y = y; gen_z = z; gen_w = w;
    tick();
    gen_valid = 1'b0; gen_x = 32'hDEAD_BEEF; gen_y = 32'hDEAD_BEEF; gen_z = 32'hDEAD_BEEF; gen_w = 32'hDEAD_BEEF;
  endtask

  task automatic test_reset();
    apply_reset();
    n_cmp++;
    if ({reseed_ack, rsp_valid, rsp_x, rsp_y, rsp_z, rsp_w, rsp_id, gen_pop, gen_reseed,
         gen_seed, busy, timeout_err} !== 174'd0) begin
      n_err++; $display("FAIL reset_outputs busy=%b rsp_valid=%b gen_pop=%b exp all zero", busy, rsp_valid, gen_pop);
    end
    tick(); tick();
    n_cmp++;
    if (busy !== 1'b0 || gen_pop !== 1'b0) begin
      n_err++; $display("FAIL idle_no_request busy=%b gen_pop=%b exp 0 0", busy, gen_pop);
    end
  endtask

  task automatic test_single();
    bit ok;
    apply_reset();
    pop_cnt = 0;
    req_pop = 4'b0001;
    wait_pop(ok);
    n_cmp++;
    if (!ok || busy !== 1'b1) begin
      n_err++; $display("FAIL single_issue ok=%0d busy=%b exp 1 1", ok, busy);
    end
    gen_return(32'h4000_0000, 32'h1234_5678, 32'h0000_0000, 32'hC000_0000);
    n_cmp++;
    if (rsp_valid !== 4'b0001 || rsp_id !== 2'd0 || rsp_x !== 32'h4000_0000 || rsp_y !== 32'h1234_5678 ||
        rsp_z !== 32'h0000_0000 || rsp_w !== 32'hC000_0000) begin
      n_err++; $display("FAIL single_rsp valid=%b id=%0d x=%h w=%h exp 0001 0 40000000 c0000000", rsp_valid, rsp_id, rsp_x, rsp_w);
    end
    tick(); tick(); tick();
    n_cmp++;
    if (rsp_valid !== 4'b0001 || rsp_x !== 32'h4000_0000 || rsp_w !== 32'hC000_0000 || pop_cnt !== 1) begin
      n_err++; $display("FAIL single_hold valid=%b x=%h w=%h pops=%0d exp 0001 40000000 c0000000 1", rsp_valid, rsp_x, rsp_w, pop_cnt);
    end
    rsp_ready = 4'b0001; req_pop = 4'b0000;
    tick();
    rsp_ready = 4'b0000;
    n_cmp++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL single_release valid=%b busy=%b exp 0000 0", rsp_valid, busy);
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [1:0] exp_id;
    apply_reset();
    req_pop = 4'b1111;
    for (int n = 0; n < 8; n++) begin
      exp_id = n[1:0];
      wait_pop(ok);
      gen_return(32'h1000_0000 + 32'(n), 32'd1, 32'd2, 32'd3);
      n_cmp++;
      if (!ok || rsp_id !== exp_id || rsp_valid !== (4'b0001 << exp_id) || rsp_x !== 32'h1000_0000 + 32'(n)) begin
        n_err++; $display("FAIL rr_order n=%0d ok=%0d id=%0d valid=%b x=%h exp id %0d", n, ok, rsp_id, rsp_valid, rsp_x, exp_id);
      end
      rsp_ready = 4'b0001 << exp_id;
      tick();
      rsp_ready = 4'b0000;
    end
    req_pop = 4'b0000;
  endtask

  task automatic test_reseed();
    bit ok;
    apply_reset();
    req_seed = {32'h0000_0033, 32'h0000_0005, 32'h0000_0011, 32'h0000_0007};
    req_reseed = 4'b0100;
    req_pop = 4'b1100;
    tick();
    n_cmp++;
    if (gen_reseed !== 1'b1 || gen_seed !== 32'd5 || reseed_ack !== 4'b0100 || gen_pop !== 1'b0) begin
      n_err++; $display("FAIL reseed_strobe reseed=%b seed=%h ack=%b pop=%b exp 1 5 0100 0", gen_reseed, gen_seed, reseed_ack, gen_pop);
    end
    req_reseed = 4'b0000;
    tick();
    n_cmp++;
    if (gen_reseed !== 1'b0 || reseed_ack !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL reseed_pulse reseed=%b ack=%b busy=%b exp 0 0000 0", gen_reseed, reseed_ack, busy);
    end
    wait_pop(ok);
    gen_return(32'h3333_0000, 32'd0, 32'd0, 32'd0);
    n_cmp++;
    if (!ok || rsp_id !== 2'd3 || rsp_valid !== 4'b1000) begin
      n_err++; $display("FAIL reseed_next_turn ok=%0d id=%0d valid=%b exp 3 1000", ok, rsp_id, rsp_valid);
    end
    rsp_ready = 4'b1000; req_pop = 4'b0100;
    tick();
    rsp_ready = 4'b0000;
    wait_pop(ok);
    gen_return(32'h2222_0000, 32'd0, 32'd0, 32'd0);
    n_cmp++;
    if (!ok || rsp_id !== 2'd2 || rsp_valid !== 4'b0100 || rsp_x !== 32'h2222_0000) begin
      n_err++; $display("FAIL reseed_pop_served ok=%0d id=%0d valid=%b x=%h exp 2 0100 22220000", ok, rsp_id, rsp_valid, rsp_x);
    end
    rsp_ready = 4'b0100; req_pop = 4'b0000;
    tick();
    rsp_ready = 4'b0000;
  endtask

  task automatic test_backpressure();
    bit ok;
    int c0;
    apply_reset();
    req_pop = 4'b0010;
    wait_pop(ok);
    gen_return(32'h2222_0001, 32'h2222_0002, 32'h2222_0003, 32'h2222_0004);
    rsp_ready = 4'b1101;
    req_pop = 4'b0011;
    c0 = pop_cnt;
    for (int c = 0; c < 10; c++) begin
      tick();
      n_cmp++;
      if (rsp_valid !== 4'b0010 || rsp_id !== 2'd1 || rsp_x !== 32'h2222_0001 || rsp_w !== 32'h2222_0004 ||
          busy !== 1'b1 || pop_cnt !== c0) begin
        n_err++; $display("FAIL bp_hold c=%0d valid=%b x=%h busy=%b pops=%0d exp 0010 22220001 1 %0d", c, rsp_valid, rsp_x, busy, pop_cnt, c0);
      end
    end
    rsp_ready = 4'b0010; req_pop = 4'b0001;
    tick();
    rsp_ready = 4'b0000;
    n_cmp++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      n_err++; $display("FAIL bp_release valid=%b busy=%b exp 0000 0", rsp_valid, busy);
    end
    tick();
    n_cmp++;
    if (gen_pop !== 1'b1) begin
      n_err++; $display("FAIL bp_next_issue gen_pop=%b exp 1", gen_pop);
    end
    req_pop = 4'b0000;
  endtask

  task automatic test_timeout();
    bit ok;
    apply_reset();
    req_pop = 4'b0001;
    wait_pop(ok);
    repeat (64) tick();
    n_cmp++;
    if (!ok || busy !== 1'b1 || timeout_err !== 1'b0) begin
      n_err++; $display("FAIL to_last_wait ok=%0d busy=%b err=%b exp 1 1 0", ok, busy, timeout_err);
    end
    tick();
    n_cmp++;
    if (busy !== 1'b0 || timeout_err !== 1'b1 || gen_pop !== 1'b0) begin
      n_err++; $display("FAIL to_abort busy=%b err=%b pop=%b exp 0 1 0", busy, timeout_err, gen_pop);
    end
    tick();
    n_cmp++;
    if (gen_pop !== 1'b1) begin
      n_err++; $display("FAIL to_rearbitrate gen_pop=%b exp 1", gen_pop);
    end
    gen_return(32'h7777_0000, 32'd0, 32'd0, 32'd0);
    rsp_ready = 4'b0001; req_pop = 4'b0000;
    tick();
    rsp_ready = 4'b0000;
    n_cmp++;
    if (timeout_err !== 1'b1 || rsp_valid !== 4'b0000) begin
      n_err++; $display("FAIL to_sticky err=%b valid=%b exp 1 0000", timeout_err, rsp_valid);
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    req_pop = 4'b0001;
    wait_pop(ok);
    tick();
    #3 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({reseed_ack, rsp_valid, rsp_x, rsp_y, rsp_z, rsp_w, rsp_id, gen_pop, gen_reseed,
         gen_seed, busy, timeout_err} !== 174'd0) begin
      n_err++; $display("FAIL async_reset ok=%0d busy=%b err=%b rsp_x=%h exp all zero", ok, busy, timeout_err, rsp_x);
    end
    @(negedge clk);
    rst_n = 1'b1; req_pop = 4'b0000;
    tick();
    gen_valid = 1'b1; gen_x = 32'h5555_5555;
    tick();
    gen_valid = 1'b0;
    tick();
    n_cmp++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0 || gen_pop !== 1'b0 || rsp_x !== 32'd0) begin
      n_err++; $display("FAIL late_gen_valid valid=%b busy=%b pop=%b x=%h exp 0000 0 0 0", rsp_valid, busy, gen_pop, rsp_x);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_reseed();
    test_backpressure();
    test_timeout();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
